// File: rtl/ahb_apb_bridge_param_if.sv
// Bus bundle for the AHB-Lite to APB bridge: AHB slave-side and APB master-side signals.
// The slave modport is the bridge's view; the master modport is the agents' view.
interface bridge_if #(
  parameter int WIDTH  = 32,
  parameter int SLAVES = 4
);
  logic [1:0]        Htrans;
  logic [WIDTH-1:0]  Haddr;
  logic              Hwrite;
  logic [2:0]        Hsize;
  logic [2:0]        Hburst;
  logic [WIDTH-1:0]  Hwdata;
  logic              Hreadyin;
  logic              Hreadyout;
  logic [1:0]        Hresp;
  logic [WIDTH-1:0]  Hrdata;
  logic [WIDTH-1:0]  Paddr;
  logic [WIDTH-1:0]  Pwdata;
  logic              Pwrite;
  logic [SLAVES-1:0] Pselx;
  logic              Penable;
  logic [WIDTH-1:0]  Prdata;
  logic              Pready;
  logic              Pslverr;

  modport slave (
    input  Htrans, Haddr, Hwrite, Hsize, Hburst, Hwdata, Hreadyin,
    input  Prdata, Pready, Pslverr,
    output Hreadyout, Hresp, Hrdata,
    output Paddr, Pwdata, Pwrite, Pselx, Penable
  );

  modport master (
    output Htrans, Haddr, Hwrite, Hsize, Hburst, Hwdata, Hreadyin,
    output Prdata, Pready, Pslverr,
    input  Hreadyout, Hresp, Hrdata,
    input  Paddr, Pwdata, Pwrite, Pselx, Penable
  );
endinterface

// File: rtl/ahb_apb_bridge_param.sv
// AHB-Lite slave to APB master bridge: each AHB beat becomes one APB SETUP/ACCESS transfer,
// with region decode onto one-hot Pselx, wait states, slave error and a Pready timeout.
module ahb_apb_bridge_param #(
  parameter int               WIDTH     = 32,
  parameter int               SLAVES    = 4,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int               SEL_LSB   = 24,
  parameter int               TIMEOUT   = 16
) (
  input  logic    clock,
  input  logic    Hresetn,
  bridge_if.slave bus
);

  localparam int               IDXW       = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int               CNTW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int               TMO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNTW-1:0]  TMO_LAST_V = CNTW'(TMO_LAST);
  localparam logic [2:0]       MAX_SIZE   = 3'($clog2(WIDTH / 8));
  localparam logic [WIDTH-1:0] NUM_SLAVES = WIDTH'(SLAVES);

  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SLAVES-1:0] r_sel;
  logic [WIDTH-1:0]  r_addr;
  logic              r_write;
  logic [WIDTH-1:0]  r_wdata;
  logic [WIDTH-1:0]  r_rdata;
  logic [CNTW-1:0]   r_cnt;

  logic [WIDTH-1:0]  w_offset;
  logic [WIDTH-1:0]  w_region;
  logic              w_hit;
  logic [IDXW-1:0]   w_idx;
  logic [SLAVES-1:0] w_sel_dec;
  logic              w_accept;
  logic              w_timeout;
  logic              w_unused;

  // The region index is only meaningful once the address is known to lie above BASE_ADDR.
  assign w_offset  = bus.Haddr - BASE_ADDR;
  assign w_region  = w_offset >> SEL_LSB;
  assign w_hit     = (bus.Haddr >= BASE_ADDR) && (w_region < NUM_SLAVES) && (bus.Hsize <= MAX_SIZE);
  assign w_idx     = w_region[IDXW-1:0];
  assign w_sel_dec = w_hit ? (SLAVES'(1) << w_idx) : '0;
  assign w_accept  = bus.Hreadyin && bus.Htrans[1] && (r_state inside {IDLE, DONE, ERR2});
  assign w_timeout = (TIMEOUT > 0) && (r_cnt == TMO_LAST_V);
  assign w_unused  = ^{bus.Htrans[0], bus.Hburst};

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    bus.Pselx     = '0;
    bus.Penable   = 1'b0;
    case (r_state)
      IDLE, DONE, ERR2: begin
        if (r_state == ERR2) bus.Hresp = 2'b01;
        if (w_accept)        w_next = !w_hit ? ERR1 : (bus.Hwrite ? WDATA : SETUP);
        else                 w_next = IDLE;
      end
      WDATA: begin
        bus.Hreadyout = 1'b0;
        w_next        = SETUP;
      end
      SETUP: begin
        bus.Hreadyout = 1'b0;
        bus.Pselx     = r_sel;
        w_next        = ACCESS;
      end
      ACCESS: begin
        bus.Hreadyout = 1'b0;
        bus.Pselx     = r_sel;
        bus.Penable   = 1'b1;
        if (bus.Pready)     w_next = bus.Pslverr ? ERR1 : DONE;
        else if (w_timeout) w_next = ERR1;
      end
      ERR1: begin
        bus.Hreadyout = 1'b0;
        bus.Hresp     = 2'b01;
        w_next        = ERR2;
      end
      default: w_next = IDLE;
    endcase
  end

  // The wait counter restarts in SETUP so every ACCESS phase gets the full timeout budget.
  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      r_sel   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.Haddr;
        r_write <= bus.Hwrite;
        r_sel   <= w_sel_dec;
      end
      if (r_state == WDATA) r_wdata <= bus.Hwdata;
      if (r_state == SETUP)                        r_cnt <= '0;
      else if (r_state == ACCESS && !bus.Pready)   r_cnt <= r_cnt + 1'b1;
      if (r_state == ACCESS && bus.Pready && !bus.Pslverr && !r_write) r_rdata <= bus.Prdata;
    end
  end

  assign bus.Paddr  = r_addr;
  assign bus.Pwdata = r_wdata;
  assign bus.Pwrite = r_write;
  assign bus.Hrdata = r_rdata;

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Directed bench for ahb_apb_bridge_param: the bench acts as AHB master and APB slave,
// predicts each response from a small model and checks it through a scoreboard queue.
module tb_ahb_apb_bridge_param;

  localparam int          WIDTH     = 32;
  localparam int          SLAVES    = 4;
  localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
  localparam int          SEL_LSB   = 24;
  localparam int          TIMEOUT   = 16;

  typedef struct {
    logic [1:0]        hresp;
    logic [WIDTH-1:0]  hrdata;
    int                latency;
    int                penCycles;
    logic [SLAVES-1:0] sel;
    logic              errCase;
  } expect_t;

  logic             clock = 1'b0;
  logic             Hresetn;
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] lastRdata = '0;
  expect_t          sbQueue[$];

  bridge_if #(.WIDTH(WIDTH), .SLAVES(SLAVES)) bus ();

  ahb_apb_bridge_param #(
    .WIDTH(WIDTH), .SLAVES(SLAVES), .BASE_ADDR(BASE_ADDR), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .Hresetn(Hresetn),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    bus.Htrans = 2'b00;
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // One AHB beat from the address phase to the final response; the bench also plays the APB slave,
  // raising Pready after `waits` ACCESS cycles (never, if waits reaches the timeout).
  task automatic applyStimulus(input string name, input logic [WIDTH-1:0] addr, input logic write,
                               input logic [2:0] size, input logic [WIDTH-1:0] wdata,
                               input logic [WIDTH-1:0] rdata, input int waits, input logic slverr);
    expect_t           exp;
    expect_t           got;
    logic              hit;
    logic              abortCase;
    int                idx;
    int                cyc;
    int                penCount;
    logic              badSel;
    logic              prevReady;
    logic [1:0]        prevResp;
    logic [SLAVES-1:0] seenSel;
    logic [WIDTH-1:0]  seenPaddr;
    logic [WIDTH-1:0]  seenPwdata;
    logic              seenPwrite;

    hit       = (addr >= BASE_ADDR) && (addr < BASE_ADDR + (SLAVES << SEL_LSB)) && (size <= 3'd2);
    idx       = hit ? int'((addr - BASE_ADDR) >> SEL_LSB) : 0;
    abortCase = hit && (TIMEOUT > 0) && (waits >= TIMEOUT);
    exp.errCase   = !hit || slverr || abortCase;
    exp.penCycles = !hit ? 0 : (abortCase ? TIMEOUT : waits + 1);
    exp.latency   = !hit ? 2 : (write ? 3 : 2) + exp.penCycles + (exp.errCase ? 1 : 0);
    exp.hresp     = exp.errCase ? 2'b01 : 2'b00;
    exp.sel       = hit ? SLAVES'(1 << idx) : '0;
    if (hit && !write && !exp.errCase) lastRdata = rdata;
    exp.hrdata    = lastRdata;
    sbQueue.push_back(exp);

    $display("[TB] step: %s", name);
    bus.Htrans = 2'b10;
    bus.Haddr  = addr;
    bus.Hwrite = write;
    bus.Hsize  = size;
    bus.Pready = 1'b0;
    @(negedge clock);
    bus.Htrans = 2'b00;
    bus.Hwdata = wdata;
    checkOutput({name, " c1 Pselx"}, 64'(bus.Pselx), 64'((hit && !write) ? exp.sel : '0));

    cyc = 1; penCount = 0; badSel = 1'b0; prevReady = 1'b1; prevResp = 2'b00;
    seenSel = '0; seenPaddr = '0; seenPwdata = '0; seenPwrite = 1'b0;
    while (bus.Hreadyout !== 1'b1 && cyc < 100) begin
      if (bus.Pselx !== '0) begin
        seenSel    = seenSel | bus.Pselx;
        seenPaddr  = bus.Paddr;
        seenPwrite = bus.Pwrite;
        if (bus.Pselx !== exp.sel) badSel = 1'b1;
      end
      if (bus.Penable === 1'b1) begin
        if (bus.Pselx === '0) badSel = 1'b1;
        penCount++;
        seenPwdata  = bus.Pwdata;
        bus.Pready  = (penCount > waits);
        bus.Prdata  = rdata;
        bus.Pslverr = slverr;
      end else begin
        bus.Pready = 1'b0;
      end
      prevReady = bus.Hreadyout;
      prevResp  = bus.Hresp;
      @(negedge clock);
      cyc++;
    end
    bus.Pready  = 1'b0;
    bus.Pslverr = 1'b0;

    got = sbQueue.pop_front();
    checkOutput({name, " latency"}, 64'(cyc), 64'(got.latency));
    checkOutput({name, " Hresp"}, 64'(bus.Hresp), 64'(got.hresp));
    checkOutput({name, " Hrdata"}, 64'(bus.Hrdata), 64'(got.hrdata));
    checkOutput({name, " Penable cycles"}, 64'(penCount), 64'(got.penCycles));
    checkOutput({name, " Pselx seen"}, 64'(seenSel), 64'(got.sel));
    checkOutput({name, " Pselx legal"}, 64'(badSel), 64'(0));
    checkOutput({name, " idle Pselx"}, 64'(bus.Pselx), 64'(0));
    if (got.errCase) begin
      checkOutput({name, " ERR1 Hreadyout"}, 64'(prevReady), 64'(0));
      checkOutput({name, " ERR1 Hresp"}, 64'(prevResp), 64'(2'b01));
    end
    if (hit) begin
      checkOutput({name, " Paddr"}, 64'(seenPaddr), 64'(addr));
      checkOutput({name, " Pwrite"}, 64'(seenPwrite), 64'(write));
    end
    if (hit && write) checkOutput({name, " Pwdata"}, 64'(seenPwdata), 64'(wdata));
  endtask

  initial begin
    bus.Htrans   = 2'b00;
    bus.Haddr    = '0;
    bus.Hwrite   = 1'b0;
    bus.Hsize    = 3'd2;
    bus.Hburst   = 3'd0;
    bus.Hwdata   = '0;
    bus.Hreadyin = 1'b1;
    bus.Prdata   = '0;
    bus.Pready   = 1'b0;
    bus.Pslverr  = 1'b0;
    Hresetn      = 1'b1;
    #1 Hresetn   = 1'b0;
    @(negedge clock);
    checkOutput("reset Hreadyout", 64'(bus.Hreadyout), 64'(1));
    checkOutput("reset Hresp", 64'(bus.Hresp), 64'(0));
    checkOutput("reset Hrdata", 64'(bus.Hrdata), 64'(0));
    checkOutput("reset Paddr", 64'(bus.Paddr), 64'(0));
    checkOutput("reset Pwdata", 64'(bus.Pwdata), 64'(0));
    checkOutput("reset Pwrite", 64'(bus.Pwrite), 64'(0));
    checkOutput("reset Pselx", 64'(bus.Pselx), 64'(0));
    checkOutput("reset Penable", 64'(bus.Penable), 64'(0));
    @(negedge clock);
    Hresetn = 1'b1;
    idleCycles(2);
    checkOutput("idle Hreadyout", 64'(bus.Hreadyout), 64'(1));

    applyStimulus("read s1", 32'h8100_0010, 1'b0, 3'd2, '0, 32'hDEAD_BEEF, 0, 1'b0);
    idleCycles(1);
    applyStimulus("write s3 waits", 32'h8300_0004, 1'b1, 3'd2, 32'hA5A5_0001, '0, 3, 1'b0);
    idleCycles(1);
    applyStimulus("read s0 slverr", 32'h8000_0020, 1'b0, 3'd2, '0, 32'h1234_5678, 0, 1'b1);
    idleCycles(1);
    applyStimulus("write miss", 32'h0000_0000, 1'b1, 3'd2, 32'hFFFF_0000, '0, 0, 1'b0);
    applyStimulus("read bad size", 32'h8000_0000, 1'b0, 3'd3, '0, 32'h5555_AAAA, 0, 1'b0);
    idleCycles(1);
    applyStimulus("read above range", 32'h8400_0000, 1'b0, 3'd2, '0, 32'h0BAD_0BAD, 0, 1'b0);
    idleCycles(1);
    applyStimulus("read timeout", 32'h8200_0008, 1'b0, 3'd2, '0, 32'h7777_7777, 100, 1'b0);
    idleCycles(1);
    applyStimulus("b2b read s1", 32'h8100_0100, 1'b0, 3'd2, '0, 32'h1111_2222, 1, 1'b0);
    applyStimulus("b2b read s2", 32'h8200_0200, 1'b0, 3'd1, '0, 32'h3333_4444, 0, 1'b0);
    applyStimulus("b2b write s0", 32'h80FF_FFFC, 1'b1, 3'd2, 32'hCAFE_F00D, '0, 0, 1'b0);

    // Reset while the APB slave is holding ACCESS must drop the transfer without waiting for a clock.
    $display("[TB] step: reset during ACCESS");
    bus.Htrans = 2'b10;
    bus.Haddr  = 32'h8200_0000;
    bus.Hwrite = 1'b0;
    bus.Hsize  = 3'd2;
    bus.Pready = 1'b0;
    @(negedge clock);
    bus.Htrans = 2'b00;
    @(negedge clock);
    checkOutput("pre-reset Penable", 64'(bus.Penable), 64'(1));
    #2 Hresetn = 1'b0;
    #1;
    checkOutput("async reset Pselx", 64'(bus.Pselx), 64'(0));
    checkOutput("async reset Penable", 64'(bus.Penable), 64'(0));
    checkOutput("async reset Hreadyout", 64'(bus.Hreadyout), 64'(1));
    checkOutput("async reset Hresp", 64'(bus.Hresp), 64'(0));
    checkOutput("async reset Hrdata", 64'(bus.Hrdata), 64'(0));
    checkOutput("async reset Paddr", 64'(bus.Paddr), 64'(0));
    lastRdata = '0;
    @(negedge clock);
    Hresetn = 1'b1;
    idleCycles(1);
    applyStimulus("read after reset", 32'h8300_0000, 1'b0, 3'd0, '0, 32'h0102_0304, 0, 1'b0);
    idleCycles(2);

    checkOutput("scoreboard empty", 64'(sbQueue.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
